// File: rtl/ones_count_seq.sv
// ones_count8: number of set bits in one byte.
// Latency: combinational.
// Backpressure: none.
module ones_count8 (
    input  logic [7:0] dat,
    output logic [3:0] cnt
);
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, dat[i]};
        end
    end
endmodule

// ones_count_seq: popcount or zero-count of a WIDTH-bit operand, one byte lane per cycle.
// Latency: rsp_valid rises N = WIDTH/8 cycles after the accept edge; next accept at the edge after the handshake.
// Backpressure: holds the result in RESP with rsp_count stable while rsp_ready is low; req_ready is low while busy.
module ones_count_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_zeros,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CW-1:0]    rsp_count,
    output logic             busy
);
    localparam int N  = WIDTH / 8;
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0][7:0] op;
    logic [LW-1:0]     lane;
    logic [CW-1:0]     acc;
    logic [7:0]        lane_dat;
    logic [3:0]        lane_cnt;
    logic [CW-1:0]     acc_sum;

    // the shared counter sees zero outside RUN so it never toggles on idle operands
    assign lane_dat = (state == RUN) ? op[lane] : 8'h00;
    assign acc_sum  = acc + CW'(lane_cnt);

    ones_count8 u_cnt (
        .dat (lane_dat),
        .cnt (lane_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)     state_nxt = RUN;
            RUN:     if (lane == LAST)  state_nxt = RESP;
            RESP:    if (rsp_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op        <= '0;
            lane      <= '0;
            acc       <= '0;
            rsp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op   <= req_zeros ? ~req_data : req_data;
                        lane <= '0;
                        acc  <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (lane == LAST) begin
                        rsp_count <= acc_sum;
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
endmodule
